mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ui_in  input  8  async config: [7] auto, [6:4] hold exponent E, [3] freeze, [2:0] manual mode index.
REQ-004 SHALL have port: vblank  input  1  vertical blanking from the timing generator.
REQ-005 SHALL have port: visible  input  1  active-display indicator from the timing generator.
REQ-006 SHALL have port: o_mode  output  8  one-hot current mode.
REQ-007 SHALL have port: o_idx  output  3  binary current mode index.
REQ-008 SHALL have port: o_auto  output  1  1 while the state machine is in AUTO.
REQ-009 SHALL have port: o_frame  output  1  one-clock pulse at each frame start.
REQ-010 SHALL have port: o_rampc  output  8  per-line ramp count for the DAC ramp datapath.

Function
REQ-011 SHALL pass ui_in through a two-flop synchronizer; s_ui is the second stage; ui_in reaches s_ui after 2 clocks.
REQ-012 SHALL register vblank into vb_q; frame_start = vblank & ~vb_q, one clock wide.
REQ-013 SHALL drive o_frame = frame_start as a registered copy, asserting 1 clock after frame_start.
REQ-014 SHALL update state, mode index and frame counter only in cycles where frame_start = 1.
REQ-015 SHALL implement two states, MANUAL and AUTO; o_auto = (state == AUTO).
REQ-016 MANUAL at frame_start: if s_ui[7]=0, load mode_idx <= s_ui[2:0] and fcnt <= 0.
REQ-017 MANUAL at frame_start: if s_ui[7]=1, go to AUTO with fcnt <= 0 and mode_idx unchanged.
REQ-018 AUTO at frame_start: if s_ui[7]=0, go to MANUAL with mode_idx <= s_ui[2:0] and fcnt <= 0.
REQ-019 AUTO at frame_start, s_ui[7]=1, s_ui[3]=1 (freeze): hold fcnt and mode_idx.
REQ-020 AUTO at frame_start, s_ui[7]=1, s_ui[3]=0: let H = 2^E (1..128).
REQ-021 In the case of REQ-020, if fcnt+1 >= H, set mode_idx <= mode_idx+1 (7 wraps to 0) and fcnt <= 0; otherwise fcnt <= fcnt+1.
REQ-022 fcnt SHALL be 8 bits; the >= compare handles H reduced below fcnt mid-count by stepping on the next frame_start.
REQ-023 o_mode SHALL be registered with o_mode = 1 << mode_idx, valid in the same cycle as o_idx; exactly one bit set at all times.
REQ-024 o_rampc SHALL be registered: 0 on any clock with visible=0; +1 on each clock with visible=1; wraps 255 -> 0.
REQ-025 A frame_start with visible=1 SHALL NOT affect o_rampc; ramp and sequencer are independent.

Reset
REQ-026 While rst_n=0 SHALL force: state=MANUAL, mode_idx=0, o_idx=0, o_mode=8'h01, o_auto=0, fcnt=0, o_frame=0, o_rampc=0, sync flops=0.
REQ-027 vb_q SHALL reset to 1, so a vblank already high at reset release produces no frame_start.
REQ-028 Reset asserted mid-frame or mid-hold SHALL abandon the count; the first frame_start after release behaves per REQ-016/017.

Verification
REQ-029 Reset release with vblank=1 held: no o_frame for 10 clocks; o_mode=8'h01, o_idx=0.
REQ-030 ui_in=8'h05, three vblank rising edges: o_idx=5, o_mode=8'h20 after the first edge, unchanged after the others; o_auto=0.
REQ-031 ui_in=8'h90 (auto, E=1, H=2), 8 vblank edges from o_idx=0: first edge enters AUTO with idx 0; idx 0,1,1,2,2,3,3 after edges 2..8.
REQ-032 auto E=0: o_idx steps on every frame; from idx 7 the next edge gives idx 0, o_mode=8'h01.
REQ-033 AUTO with E=3 at fcnt=5, freeze set for 4 frames, then cleared: idx unchanged while frozen; steps 3 frames after release; E changed to 1 at fcnt=5: steps on the next edge.
REQ-034 visible high 300 clocks, then low: o_rampc counts 1..255, 0, 1..44, then 0 the clock after visible falls; rst_n pulsed mid-ramp: o_rampc=0 immediately.

Source files
------------

// File: rtl/mode_sequencer.sv
// mode_sequencer
//   Selects one of eight display modes once per frame. In MANUAL the mode
//   index comes straight from the configuration bits. In AUTO the index
//   advances every 2^E frames. A freeze bit holds the count and the index.
//   A separate per-line ramp counter feeds the DAC ramp datapath.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ui_in    in   8  async config: [7] auto, [6:4] hold exponent E,
//                    [3] freeze, [2:0] manual mode index
//   vblank   in   1  vertical blanking; its rising edge starts a frame
//   visible  in   1  active-display indicator
//   o_mode   out  8  one-hot current mode
//   o_idx    out  3  binary current mode index
//   o_auto   out  1  high while in AUTO
//   o_frame  out  1  one-clock pulse, one clock after each frame start
//   o_rampc  out  8  ramp count, cleared whenever visible is low
//
// state  | meaning
// MANUAL | mode index taken from ui_in[2:0] at each frame start
// AUTO   | mode index steps every 2^E frames unless frozen

module mode_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic       vblank,
  input  logic       visible,
  output logic [7:0] o_mode,
  output logic [2:0] o_idx,
  output logic       o_auto,
  output logic       o_frame,
  output logic [7:0] o_rampc
);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sync_q;
  logic [7:0] s_ui;
  logic       vb_q;
  logic       frame_start;
  logic [2:0] mode_idx;
  logic [2:0] idx_nxt;
  logic [7:0] fcnt;
  logic [7:0] fcnt_nxt;
  logic [8:0] fcnt_inc;
  logic [8:0] hold_len;

  assign frame_start = vblank & ~vb_q;
  assign o_idx       = mode_idx;
  assign o_auto      = (state == AUTO);

  // Two-flop synchronizer for the asynchronous configuration bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 8'h00;
      s_ui   <= 8'h00;
    end else begin
      sync_q <= ui_in;
      s_ui   <= sync_q;
    end
  end

  // vb_q resets high so a vblank already asserted at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q    <= 1'b1;
      o_frame <= 1'b0;
    end else begin
      vb_q    <= vblank;
      o_frame <= frame_start;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = mode_idx;
    fcnt_nxt  = fcnt;
    fcnt_inc  = {1'b0, fcnt} + 9'd1;
    hold_len  = 9'd1 << s_ui[6:4];
    if (frame_start) begin
      case (state)
        MANUAL: begin
          fcnt_nxt = 8'd0;
          if (s_ui[7]) begin
            state_nxt = AUTO;
          end else begin
            idx_nxt = s_ui[2:0];
          end
        end
        AUTO: begin
          if (!s_ui[7]) begin
            state_nxt = MANUAL;
            idx_nxt   = s_ui[2:0];
            fcnt_nxt  = 8'd0;
          end else if (!s_ui[3]) begin
            // >= rather than == so a hold shortened mid-count still steps.
            if (fcnt_inc >= hold_len) begin
              idx_nxt  = mode_idx + 3'd1;
              fcnt_nxt = 8'd0;
            end else begin
              fcnt_nxt = fcnt_inc[7:0];
            end
          end
        end
        default: begin
          state_nxt = MANUAL;
          idx_nxt   = 3'd0;
          fcnt_nxt  = 8'd0;
        end
      endcase
    end
  end

  // o_mode is loaded from the next index so it lines up with o_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MANUAL;
      mode_idx <= 3'd0;
      fcnt     <= 8'd0;
      o_mode   <= 8'h01;
    end else begin
      state    <= state_nxt;
      mode_idx <= idx_nxt;
      fcnt     <= fcnt_nxt;
      o_mode   <= 8'd1 << idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rampc <= 8'd0;
    end else if (!visible) begin
      o_rampc <= 8'd0;
    end else begin
      o_rampc <= o_rampc + 8'd1;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
module tb_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic       vblank;
  logic       visible;
  logic [7:0] o_mode;
  logic [2:0] o_idx;
  logic       o_auto;
  logic       o_frame;
  logic [7:0] o_rampc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       auto_on;
  } exp_t;

  exp_t sb[$];
  logic [7:0] ramp_sb[$];

  mode_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .vblank  (vblank),
    .visible (visible),
    .o_mode  (o_mode),
    .o_idx   (o_idx),
    .o_auto  (o_auto),
    .o_frame (o_frame),
    .o_rampc (o_rampc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vblank rising edge; expected mode state is queued before the edge
  // and compared once o_frame shows the sequencer has acted on it.
  task automatic do_frame(input string tag, input logic [2:0] e_idx, input logic e_auto);
    exp_t e;
    logic got;
    sb.push_back('{idx: e_idx, auto_on: e_auto});
    repeat (4) @(negedge clk);
    vblank = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (o_frame === 1'b1) got = 1'b1;
    end
    chk({tag, "_frame_seen"}, {7'd0, got}, 8'd1);
    e = sb.pop_front();
    chk({tag, "_idx"},  {5'd0, o_idx}, {5'd0, e.idx});
    chk({tag, "_mode"}, o_mode, 8'd1 << e.idx);
    chk({tag, "_auto"}, {7'd0, o_auto}, {7'd0, e.auto_on});
    @(negedge clk);
    chk({tag, "_frame_width"}, {7'd0, o_frame}, 8'd0);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    ui_in   = 8'h00;
    vblank  = 1'b1;
    visible = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mode",  o_mode, 8'h01);
    chk("rst_idx",   {5'd0, o_idx}, 8'd0);
    chk("rst_auto",  {7'd0, o_auto}, 8'd0);
    chk("rst_frame", {7'd0, o_frame}, 8'd0);
    chk("rst_rampc", o_rampc, 8'd0);

    // Release with vblank already high: no frame start.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rel_no_frame", {7'd0, o_frame}, 8'd0);
    end
    chk("rel_mode", o_mode, 8'h01);
    chk("rel_idx",  {5'd0, o_idx}, 8'd0);
    vblank = 1'b0;
    repeat (3) @(negedge clk);

    // Manual selection.
    ui_in = 8'h05;
    do_frame("man1", 3'd5, 1'b0);
    do_frame("man2", 3'd5, 1'b0);
    do_frame("man3", 3'd5, 1'b0);
    ui_in = 8'h00;
    do_frame("man0", 3'd0, 1'b0);

    // Auto, E=1 (H=2).
    ui_in = 8'h90;
    do_frame("h2_e1", 3'd0, 1'b1);
    do_frame("h2_e2", 3'd0, 1'b1);
    do_frame("h2_e3", 3'd1, 1'b1);
    do_frame("h2_e4", 3'd1, 1'b1);
    do_frame("h2_e5", 3'd2, 1'b1);
    do_frame("h2_e6", 3'd2, 1'b1);
    do_frame("h2_e7", 3'd3, 1'b1);
    do_frame("h2_e8", 3'd3, 1'b1);

    // Auto, E=0: step every frame, 7 wraps to 0.
    ui_in = 8'h80;
    do_frame("h1_a", 3'd4, 1'b1);
    do_frame("h1_b", 3'd5, 1'b1);
    do_frame("h1_c", 3'd6, 1'b1);
    do_frame("h1_d", 3'd7, 1'b1);
    do_frame("h1_wrap", 3'd0, 1'b1);

    // E=3 (H=8): count to fcnt=5, freeze 4 frames, release.
    ui_in = 8'hB0;
    for (int i = 0; i < 5; i++) do_frame("h8_cnt", 3'd0, 1'b1);
    ui_in = 8'hB8;
    for (int i = 0; i < 4; i++) do_frame("frz", 3'd0, 1'b1);
    ui_in = 8'hB0;
    do_frame("unfrz1", 3'd0, 1'b1);
    do_frame("unfrz2", 3'd0, 1'b1);
    do_frame("unfrz3", 3'd1, 1'b1);
    // Back to fcnt=5, then shorten the hold to 2.
    for (int i = 0; i < 5; i++) do_frame("h8_cnt2", 3'd1, 1'b1);
    ui_in = 8'h90;
    do_frame("shorten", 3'd2, 1'b1);

    // Reset mid-hold abandons the count.
    ui_in = 8'hB0;
    do_frame("pre_rst1", 3'd2, 1'b1);
    do_frame("pre_rst2", 3'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_idx",  {5'd0, o_idx}, 8'd0);
    chk("midrst_mode", o_mode, 8'h01);
    chk("midrst_auto", {7'd0, o_auto}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_frame("post_rst1", 3'd0, 1'b1);
    do_frame("post_rst2", 3'd0, 1'b1);
    ui_in = 8'h03;
    do_frame("post_rst_man", 3'd3, 1'b0);

    // Ramp: 300 visible clocks with a frame start in the middle.
    @(negedge clk);
    visible = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      ramp_sb.push_back(8'(k));
      if (k == 100) vblank = 1'b1;
      if (k == 103) vblank = 1'b0;
      @(negedge clk);
      chk("ramp_cnt", o_rampc, ramp_sb.pop_front());
    end
    chk("ramp_last", o_rampc, 8'd44);
    visible = 1'b0;
    @(negedge clk);
    chk("ramp_clear", o_rampc, 8'd0);

    // Reset pulse mid-ramp clears the count without waiting for an edge.
    visible = 1'b1;
    repeat (20) @(negedge clk);
    chk("ramp_pre_rst", o_rampc, 8'd20);
    #2 rst_n = 1'b0;
    #1 chk("ramp_rst", o_rampc, 8'd0);
    @(negedge clk);
    visible = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ramp_after", o_rampc, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
